// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo family: status FSM state encodings.
package fifo_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101,
    RDWR     = 3'b110
  } state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer-side bundle of the parametrised FIFO: requests, data, status.
interface fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  import fifo_pkg::*;

  localparam int CNT_W = cnt_width(DEPTH);

  logic                  op_clear;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic [CNT_W-1:0]      data_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;

  modport master (
    output op_clear, wr_en, rd_en, din,
    input  dout, data_count, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  op_clear, wr_en, rd_en, din,
    output dout, data_count, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH register file: synchronous write, asynchronous read, no reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: storage, pointers, occupancy and a Moore status FSM.
//
// state    | meaning
// INIT     | cleared: pointers, count and dout zeroed
// NO_OP    | idle cycle, nothing changed
// WRITE    | entry stored at tail, count+1
// WR_ERROR | write refused, FIFO was full
// READ     | oldest entry loaded to dout, count-1
// RD_ERROR | read refused, FIFO was empty
// RDWR     | read and write together, count unchanged
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic         clk,
  input  logic         reset,
  fifo_param_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  full_w;
  logic                  empty_w;

  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (tail_q),
    .wdata (bus.din),
    .raddr (head_q),
    .rdata (ram_rdata)
  );

  // Next state is a pure function of the requests and occupancy, never of state_q.
  always_comb begin
    state_d = NO_OP;
    if (bus.op_clear) begin
      state_d = INIT;
    end else if (bus.wr_en && bus.rd_en) begin
      state_d = empty_w ? WRITE : RDWR;
    end else if (bus.wr_en) begin
      state_d = full_w ? WR_ERROR : WRITE;
    end else if (bus.rd_en) begin
      state_d = empty_w ? RD_ERROR : READ;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Side effects belong to the state being entered, so they key off state_d.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = dout_q;
    ram_we  = 1'b0;
    unique case (state_d)
      INIT: begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        dout_d  = '0;
      end
      WRITE: begin
        ram_we  = 1'b1;
        tail_d  = tail_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end
      READ: begin
        dout_d  = ram_rdata;
        head_d  = head_q + PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
      RDWR: begin
        // Async read sees the entry before this edge's write, even when head==tail.
        ram_we  = 1'b1;
        dout_d  = ram_rdata;
        head_d  = head_q + PTR_W'(1);
        tail_d  = tail_q + PTR_W'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.data_count   = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.wr_ack       = (state_q == WRITE) || (state_q == RDWR);
  assign bus.rd_ack       = (state_q == READ)  || (state_q == RDWR);
  assign bus.wr_err       = (state_q == WR_ERROR);
  assign bus.rd_err       = (state_q == RD_ERROR);

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (32 x 8): queue reference plus hand-computed checkpoints.
module tb_fifo_param;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_param_if #(.DATA_WIDTH(32), .DEPTH(8)) bus ();

  fifo_param #(
    .DATA_WIDTH (32),
    .DEPTH      (8),
    .AF_LEVEL   (7),
    .AE_LEVEL   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] q[$];
  logic [31:0] mdout;
  logic [31:0] shadow [8];
  int          wptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [31:0] d);
    q.push_back(d);
    shadow[wptr] = d;
    wptr = (wptr + 1) % 8;
  endtask

  // One clock with the given requests; every output is compared with the reference.
  task automatic cycle(input logic wr, input logic rd, input logic clr, input logic [31:0] d);
    logic ewa, ewe, era, ere;
    ewa = 1'b0; ewe = 1'b0; era = 1'b0; ere = 1'b0;
    if (clr) begin
      q.delete();
      mdout = '0;
      wptr  = 0;
    end else if (wr && rd) begin
      if (q.size() == 0) begin
        push_model(d);
        ewa = 1'b1;
      end else begin
        mdout = q.pop_front();
        push_model(d);
        ewa = 1'b1;
        era = 1'b1;
      end
    end else if (wr) begin
      if (q.size() == 8) ewe = 1'b1;
      else begin
        push_model(d);
        ewa = 1'b1;
      end
    end else if (rd) begin
      if (q.size() == 0) ere = 1'b1;
      else begin
        mdout = q.pop_front();
        era = 1'b1;
      end
    end
    bus.op_clear = clr;
    bus.wr_en    = wr;
    bus.rd_en    = rd;
    bus.din      = d;
    @(posedge clk);
    #1;
    bus.op_clear = 1'b0;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    chk("data_count",   32'(bus.data_count), 32'(q.size()));
    chk("full",         32'(bus.full),         32'(q.size() == 8));
    chk("empty",        32'(bus.empty),        32'(q.size() == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= 7));
    chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= 1));
    chk("wr_ack",       32'(bus.wr_ack), 32'(ewa));
    chk("wr_err",       32'(bus.wr_err), 32'(ewe));
    chk("rd_ack",       32'(bus.rd_ack), 32'(era));
    chk("rd_err",       32'(bus.rd_err), 32'(ere));
    chk("dout",         bus.dout, mdout);
  endtask

  task automatic wr_op(input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic rd_op();
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"},        32'(bus.data_count), 32'd0);
    chk({tag, " empty"},        32'(bus.empty), 32'd1);
    chk({tag, " almost_empty"}, 32'(bus.almost_empty), 32'd1);
    chk({tag, " dout"},         bus.dout, 32'h0);
    chk({tag, " acks_errs"},    32'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), 32'd0);
    chk({tag, " state"},        32'(dut.state_q), 32'(INIT));
  endtask

  initial begin
    int          slot;
    logic [31:0] keep;

    reset        = 1'b1;
    bus.op_clear = 1'b0;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.din      = '0;
    mdout        = '0;
    wptr         = 0;
    for (int i = 0; i < 8; i++) shadow[i] = 'x;

    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_state("por");

    // Reset in the middle of a burst at occupancy 5
    for (int i = 1; i <= 6; i++) wr_op(32'h100 + 32'(i));
    rd_op();
    chk("burst dout", bus.dout, 32'h101);
    chk("burst count", 32'(bus.data_count), 32'd5);
    bus.wr_en = 1'b1;
    bus.din   = 32'h1FF;
    #3 reset = 1'b1;
    #1 chk_reset_state("async_rst");
    q.delete();
    mdout = '0;
    wptr  = 0;
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1 chk_reset_state("rst_held");
    #2 reset = 1'b0;

    // Fill, then overflow
    for (int i = 1; i <= 8; i++) begin
      wr_op(32'h11 * 32'(i));
      if (i == 7) begin
        chk("fill af at 7", 32'(bus.almost_full), 32'd1);
        chk("fill not full at 7", 32'(bus.full), 32'd0);
      end
    end
    chk("fill full at 8", 32'(bus.full), 32'd1);
    wr_op(32'h99);
    chk("overflow wr_err", 32'(bus.wr_err), 32'd1);
    chk("overflow count", 32'(bus.data_count), 32'd8);

    // Drain, then underflow
    for (int i = 1; i <= 8; i++) begin
      rd_op();
      chk("drain dout", bus.dout, 32'h11 * 32'(i));
      if (i == 7) chk("drain ae at 1", 32'(bus.almost_empty), 32'd1);
    end
    chk("drain empty", 32'(bus.empty), 32'd1);
    rd_op();
    chk("underflow rd_err", 32'(bus.rd_err), 32'd1);
    chk("underflow dout hold", bus.dout, 32'h88);

    // Simultaneous read+write at count 3, 0 and 8
    wr_op(32'hA1); wr_op(32'hA2); wr_op(32'hA3);
    cycle(1'b1, 1'b1, 1'b0, 32'hA4);
    chk("rdwr3 dout", bus.dout, 32'hA1);
    chk("rdwr3 count", 32'(bus.data_count), 32'd3);
    chk("rdwr3 acks", 32'({bus.wr_ack, bus.rd_ack}), 32'd3);
    rd_op(); rd_op(); rd_op();
    chk("rdwr3 tail dout", bus.dout, 32'hA4);
    cycle(1'b1, 1'b1, 1'b0, 32'hB1);
    chk("rdwr0 count", 32'(bus.data_count), 32'd1);
    chk("rdwr0 rd_ack", 32'(bus.rd_ack), 32'd0);
    chk("rdwr0 rd_err", 32'(bus.rd_err), 32'd0);
    for (int i = 2; i <= 8; i++) wr_op(32'hB0 + 32'(i));
    cycle(1'b1, 1'b1, 1'b0, 32'hBF);
    chk("rdwr8 count", 32'(bus.data_count), 32'd8);
    chk("rdwr8 dout", bus.dout, 32'hB1);
    chk("rdwr8 wr_ack", 32'(bus.wr_ack), 32'd1);
    for (int i = 0; i < 8; i++) rd_op();
    chk("rdwr8 last dout", bus.dout, 32'hBF);

    // Pointer wrap: 20 writes and 20 reads interleaved
    for (int i = 0; i < 20; i++) begin
      wr_op(32'hC00 + 32'(i));
      if (i >= 3) rd_op();
    end
    rd_op(); rd_op(); rd_op();
    chk("wrap last dout", bus.dout, 32'hC13);
    chk("wrap count", 32'(bus.data_count), 32'd0);

    // op_clear beats simultaneous wr+rd at count 6
    for (int i = 0; i < 6; i++) wr_op(32'hD00 + 32'(i));
    slot = wptr;
    keep = shadow[slot];
    cycle(1'b1, 1'b1, 1'b1, 32'hDEAD);
    chk("clear state", 32'(dut.state_q), 32'(INIT));
    chk("clear count", 32'(bus.data_count), 32'd0);
    chk("clear dout", bus.dout, 32'h0);
    chk("clear mem untouched", dut.u_ram.mem[slot], keep);
    wr_op(32'hE1);
    rd_op();
    chk("post clear dout", bus.dout, 32'hE1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
